// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, sync-read imem driver, 2-entry output queue to decode.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]  pc;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic [1:0]   count;
  fetch_entry_t q0, q1;

  logic [1:0]   count_nxt;
  fetch_entry_t q0_nxt, q1_nxt;
  fetch_entry_t new_entry;
  logic [2:0]   occupancy;
  logic         pop, push, issue;

  assign imem_addr = pc;
  assign if_valid  = (count != 2'd0);
  assign if_instr  = q0.instr;
  assign if_pc     = q0.pc;

  assign pop       = if_valid & id_ready;
  // A redirect discards whatever the memory returns in the same cycle.
  assign push      = inflight & ~br_taken;
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign issue     = ~br_taken & ((occupancy < 3'd2) | pop);
  assign new_entry = '{pc: inflight_pc, instr: imem_instr};

  // q0 is always the head; q1 shifts down on pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_nxt = count;
    q0_nxt    = q0;
    q1_nxt    = q1;
    if (br_taken) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) q0_nxt = new_entry;
          else               q1_nxt = new_entry;
          count_nxt = count + 2'd1;
        end
        2'b01: begin
          q0_nxt    = q1;
          count_nxt = count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q0_nxt = new_entry;
          end else begin
            q0_nxt = q1;
            q1_nxt = new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      // NOTE: queue storage is reset too; it is only two registers and keeps if_instr/if_pc at 0 out of reset.
      q0          <= '0;
      q1          <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      count <= count_nxt;
      q0    <= q0_nxt;
      q1    <= q1_nxt;
      if (br_taken) begin
        pc       <= br_target;
        inflight <= 1'b0;
      end else if (issue) begin
        pc          <= pc + PC_STEP;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push)                  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_valid && !id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based PC-stream model, directed scenarios
// plus randomized ready/redirect traffic; second instance exercises PC wraparound.
module tb_fetch_unit;

  localparam logic [31:0] STEP = 32'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready = 1'b0;

  logic [31:0] imem_addr_w, imem_instr_w;
  logic        if_valid_w;
  logic [31:0] if_instr_w, if_pc_w;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  logic [31:0] perf_fetch_cnt_w, perf_stall_cnt_w;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Model: fetches in flight and queued, tracked only as PCs; instruction is mem_word(pc).
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic [31:0] m_out[$];
  logic [31:0] m_fetch, m_stall;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
    .br_taken(1'b0), .br_target(32'h0),
    .if_valid(if_valid_w), .if_instr(if_instr_w), .if_pc(if_pc_w),
    .id_ready(1'b1)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt_w), .perf_stall_cnt(perf_stall_cnt_w)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2200_0005;
      32'd1:   return 32'h2440_0003;
      default: return {a[15:0], a[31:16]} ^ a ^ 32'h5EED_0000;
    endcase
  endfunction

  // Synchronous-read instruction memories, one cycle of latency.
  always @(posedge clk) begin
    imem_instr   <= mem_word(imem_addr);
    imem_instr_w <= mem_word(imem_addr_w);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_pend.delete();
    m_out.delete();
    m_fetch = '0;
    m_stall = '0;
  endtask

  // Advance the model across one rising edge given the inputs held during the cycle.
  task automatic model_step(input logic rdy, input logic br, input logic [31:0] tgt);
    bit pop, issue;
    pop = (m_out.size() != 0) && rdy;
    if (m_out.size() != 0 && !rdy) m_stall++;
    if (br) begin
      m_out.delete();
      m_pend.delete();
      m_pc = tgt;
    end else begin
      issue = ((m_out.size() + m_pend.size()) < 2) || pop;
      if (pop) void'(m_out.pop_front());
      if (m_pend.size() != 0) begin
        check("push_room", {31'b0, m_out.size() < 2}, 32'd1);
        m_out.push_back(m_pend.pop_front());
        m_fetch++;
      end
      if (issue) begin
        m_pend.push_back(m_pc);
        m_pc += STEP;
      end
    end
  endtask

  task automatic compare();
    check("valid", {31'b0, if_valid}, {31'b0, m_out.size() != 0});
    if (m_out.size() != 0) begin
      check("pc", if_pc, m_out[0]);
      check("instr", if_instr, mem_word(m_out[0]));
    end
    check("imem_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_stall", perf_stall_cnt, m_stall);
`endif
  endtask

  task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    id_ready  = rdy;
    br_taken  = br;
    br_target = tgt;
    #1;
    compare();
    model_step(rdy, br, tgt);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_instr"}, if_instr, 32'h0);
    check({tag, "_pc"}, if_pc, 32'h0);
    check({tag, "_wrap_addr"}, imem_addr_w, 32'hFFFF_FFFF);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_perf_fetch"}, perf_fetch_cnt, 32'h0);
    check({tag, "_perf_stall"}, perf_stall_cnt, 32'h0);
`endif
  endtask

  // Reset is released shortly after a rising edge; the next edge ends cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    id_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    #1;
    reset_checks("rst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    // Startup stream and wraparound instance.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, 1'b0, 32'h0);
      case (c)
        1: begin
          check("startA_valid1", {31'b0, if_valid}, 32'd0);
          check("wrap_valid1", {31'b0, if_valid_w}, 32'd0);
        end
        2: begin
          check("startA_pc2", if_pc, 32'h0);
          check("startA_instr2", if_instr, 32'h2200_0005);
          check("wrap_pc2", if_pc_w, 32'hFFFF_FFFF);
          check("wrap_valid2", {31'b0, if_valid_w}, 32'd1);
        end
        3: begin
          check("startA_pc3", if_pc, 32'h1);
          check("startA_instr3", if_instr, 32'h2440_0003);
          check("wrap_pc3", if_pc_w, 32'h0);
          check("wrap_instr3", if_instr_w, 32'h2200_0005);
        end
        4: begin
          check("startA_pc4", if_pc, 32'h2);
          check("wrap_pc4", if_pc_w, 32'h1);
        end
        default: ;
      endcase
    end

    // Decode stall cycles 2..6: queue fills with PCs 0,1 and issue stops.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      cycle(!(c >= 2 && c <= 6), 1'b0, 32'h0);
      if (c == 6) begin
        check("stall_pc", if_pc, 32'h0);
        check("stall_addr", imem_addr, 32'h2);
        check("stall_valid", {31'b0, if_valid}, 32'd1);
      end
      if (c == 7) check("stall_release_pc", if_pc, 32'h0);
      if (c == 8) check("stall_next_pc", if_pc, 32'h1);
    end

    // Redirect at cycle 6 to 0x10.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      cycle(1'b1, c == 6, 32'h10);
      if (c == 7 || c == 8) check("br_bubble", {31'b0, if_valid}, 32'd0);
      if (c == 9) begin
        check("br_target_pc", if_pc, 32'h10);
        check("br_target_valid", {31'b0, if_valid}, 32'd1);
      end
    end

    // Redirect coinciding with a pop at cycle 4.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      cycle(1'b1, c == 4, 32'h40);
      if (c == 4) check("brpop_head", if_pc, 32'h2);
      if (c == 5 || c == 6) check("brpop_bubble", {31'b0, if_valid}, 32'd0);
      if (c == 7) check("brpop_target", if_pc, 32'h40);
      if (c == 8) check("brpop_next", if_pc, 32'h41);
    end

    // Asynchronous reset in the middle of a full-queue stall.
    do_reset();
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, 32'h0);
    check("full_valid", {31'b0, if_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("async");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized ready/redirect traffic, including targets near the top of the address space.
    for (int c = 0; c < 600; c++) begin
      logic        rdy, br;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 9) < 7);
      br  = ($urandom_range(0, 23) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      cycle(rdy, br, tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
